sm_dm_arbiter: RTL and testbench



---
 rtl/sm_dm_arbiter_pkg.sv | 21 ++
 rtl/sm_dm_watchdog.sv | 40 ++++
 rtl/sm_dm_arbiter.sv | 147 ++++++++++++++
 tb/tb_sm_dm_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_dm_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter and its watchdog.
package sm_dm_arbiter_pkg;

  typedef enum logic {
    DMA_ST_IDLE = 1'b0,
    DMA_ST_BUSY = 1'b1
  } arbState_t;

  typedef enum logic {
    DMA_M0 = 1'b0,
    DMA_M1 = 1'b1
  } arbMaster_t;

  localparam int unsigned DMA_DEFAULT_TIMEOUT = 255;

  // Counter width able to hold 0..t; at least one bit so a disabled watchdog still elaborates.
  function automatic int unsigned wdCountWidth(input int unsigned t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/sm_dm_watchdog.sv
// Slave-wait watchdog: clears on grant, counts stalled BUSY cycles, flags the terminal count.
module sm_dm_watchdog
  import sm_dm_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DMA_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = wdCountWidth(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : gNoWd
      assign expire = 1'b0;
    end else begin : gWd
      localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);
      localparam logic [CW-1:0] MAXC = CW'(TIMEOUT);

      logic [CW-1:0] count;

      // Saturating wait counter; never wraps back to a non-terminal value.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          count <= '0;
        end else if (clr) begin
          count <= '0;
        end else if (en && (count != MAXC)) begin
          count <= count + CW'(1);
        end
      end

      assign expire = (count == TERM);
    end
  endgenerate

endmodule

// File: rtl/sm_dm_arbiter.sv
// Round-robin two-master arbiter sharing one data-memory slave, with a stall watchdog.
module sm_dm_arbiter
  import sm_dm_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = DMA_DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_we,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_we,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic                  s_we,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_valid,
  input  logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_rdata,

  output logic                  arb_owner,
  output logic                  arb_busy,
  output logic                  arb_timeout
);

  arbState_t  state;
  arbState_t  stateNext;
  arbMaster_t owner;
  arbMaster_t lastOwner;
  arbMaster_t winner;
  logic       grant;
  logic       done;
  logic       abort;
  logic       expire;

  sm_dm_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) uWatchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (grant),
    .en     ((state == DMA_ST_BUSY) && !s_ready),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= DMA_ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Arbitration, completion detection and the combinational ready/rdata return path.
  always_comb begin
    stateNext   = state;
    grant       = 1'b0;
    winner      = DMA_M0;
    done        = 1'b0;
    abort       = 1'b0;
    arb_timeout = 1'b0;
    m0_ready    = ~m0_valid;
    m1_ready    = ~m1_valid;
    m0_rdata    = '0;
    m1_rdata    = '0;

    case (state)
      DMA_ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          grant     = 1'b1;
          stateNext = DMA_ST_BUSY;
          if (m0_valid && m1_valid) begin
            winner = (lastOwner == DMA_M0) ? DMA_M1 : DMA_M0;
          end else begin
            winner = m1_valid ? DMA_M1 : DMA_M0;
          end
        end
      end

      DMA_ST_BUSY: begin
        // A real completion always beats a coincident expiry.
        abort       = expire && !s_ready;
        done        = s_ready || abort;
        arb_timeout = abort;
        if (done) begin
          stateNext = DMA_ST_IDLE;
          if (owner == DMA_M0) begin
            m0_ready = 1'b1;
            if (s_ready) m0_rdata = s_rdata;
          end else begin
            m1_ready = 1'b1;
            if (s_ready) m1_rdata = s_rdata;
          end
        end
      end

      default: begin
        stateNext = DMA_ST_IDLE;
      end
    endcase
  end

  // Request registers toward the slave; fields hold their last value between accesses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_valid   <= 1'b0;
      s_addr    <= '0;
      s_we      <= 1'b0;
      s_wdata   <= '0;
      arb_busy  <= 1'b0;
      owner     <= DMA_M0;
      lastOwner <= DMA_M1;
    end else if (grant) begin
      s_valid  <= 1'b1;
      arb_busy <= 1'b1;
      owner    <= winner;
      if (winner == DMA_M1) begin
        s_addr  <= m1_addr;
        s_we    <= m1_we;
        s_wdata <= m1_wdata;
      end else begin
        s_addr  <= m0_addr;
        s_we    <= m0_we;
        s_wdata <= m0_wdata;
      end
    end else if (done) begin
      s_valid   <= 1'b0;
      arb_busy  <= 1'b0;
      lastOwner <= owner;
    end
  end

  assign arb_owner = owner;

endmodule

// File: tb/tb_sm_dm_arbiter.sv
// Self-checking bench for sm_dm_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_sm_dm_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TA = 4;
  localparam int unsigned TB = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_we, m1_we, m0_valid, m1_valid;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          s_ready;
  logic [DW-1:0] s_rdata;

  logic          a_m0_ready, a_m1_ready, a_s_we, a_s_valid, a_owner, a_busy, a_timeout;
  logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_s_wdata;
  logic [AW-1:0] a_s_addr;
  logic          b_m0_ready, b_m1_ready, b_s_we, b_s_valid, b_owner, b_busy, b_timeout;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_s_wdata;
  logic [AW-1:0] b_s_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sm_dm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TA)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_valid(m0_valid),
    .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata),
    .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_valid(m1_valid),
    .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
    .s_addr(a_s_addr), .s_we(a_s_we), .s_wdata(a_s_wdata), .s_valid(a_s_valid),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .arb_owner(a_owner), .arb_busy(a_busy), .arb_timeout(a_timeout)
  );

  sm_dm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TB)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_valid(m0_valid),
    .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
    .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_valid(m1_valid),
    .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
    .s_addr(b_s_addr), .s_we(b_s_we), .s_wdata(b_s_wdata), .s_valid(b_s_valid),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .arb_owner(b_owner), .arb_busy(b_busy), .arb_timeout(b_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_wdata = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_wdata = '0;
    s_ready  = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++; if (a_s_valid !== 1'b0) begin errors++; $display("FAIL reset_a_s_valid got %0h want 0", a_s_valid); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy got %0h want 0", a_busy); end
    checks++; if (a_owner !== 1'b0) begin errors++; $display("FAIL reset_a_owner got %0h want 0", a_owner); end
    checks++; if (a_s_addr !== '0 || a_s_we !== 1'b0 || a_s_wdata !== '0) begin errors++; $display("FAIL reset_a_s_fields got %0h/%0h/%0h want 0/0/0", a_s_addr, a_s_we, a_s_wdata); end
    checks++; if (a_timeout !== 1'b0) begin errors++; $display("FAIL reset_a_timeout got %0h want 0", a_timeout); end
    checks++; if (a_m0_ready !== 1'b1 || a_m1_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %0h/%0h want 1/1", a_m0_ready, a_m1_ready); end
    checks++; if (a_m0_rdata !== '0 || a_m1_rdata !== '0) begin errors++; $display("FAIL reset_a_rdata got %0h/%0h want 0/0", a_m0_rdata, a_m1_rdata); end
    checks++; if (b_s_valid !== 1'b0 || b_busy !== 1'b0 || b_owner !== 1'b0 || b_timeout !== 1'b0) begin errors++; $display("FAIL reset_b_ctrl got %0h%0h%0h%0h want 0000", b_s_valid, b_busy, b_owner, b_timeout); end
    checks++; if (b_s_addr !== '0 || b_s_we !== 1'b0 || b_s_wdata !== '0) begin errors++; $display("FAIL reset_b_s_fields got %0h/%0h/%0h want 0/0/0", b_s_addr, b_s_we, b_s_wdata); end
    checks++; if (b_m0_ready !== 1'b1 || b_m1_ready !== 1'b1 || b_m0_rdata !== '0 || b_m1_rdata !== '0) begin errors++; $display("FAIL reset_b_ready got %0h/%0h/%0h/%0h want 1/1/0/0", b_m0_ready, b_m1_ready, b_m0_rdata, b_m1_rdata); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h10; m0_we = 1'b0;
    @(negedge clk);
    checks++; if (a_m0_ready !== 1'b0 || a_m1_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready got %0h/%0h want 0/1", a_m0_ready, a_m1_ready); end
    checks++; if (a_s_valid !== 1'b0) begin errors++; $display("FAIL single_idle_s_valid got %0h want 0", a_s_valid); end
    tick();
    s_ready = 1'b1; s_rdata = 32'hCAFE0001;
    @(negedge clk);
    checks++; if (a_s_valid !== 1'b1 || a_s_addr !== 32'h10 || a_s_we !== 1'b0) begin errors++; $display("FAIL single_s_req got %0h/%0h/%0h want 1/10/0", a_s_valid, a_s_addr, a_s_we); end
    checks++; if (a_m0_ready !== 1'b1 || a_m0_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL single_m0_resp got %0h/%0h want 1/cafe0001", a_m0_ready, a_m0_rdata); end
    checks++; if (a_m1_ready !== 1'b1 || a_m1_rdata !== '0) begin errors++; $display("FAIL single_m1 got %0h/%0h want 1/0", a_m1_ready, a_m1_rdata); end
    checks++; if (a_owner !== 1'b0 || a_busy !== 1'b1 || a_timeout !== 1'b0) begin errors++; $display("FAIL single_status got %0h/%0h/%0h want 0/1/0", a_owner, a_busy, a_timeout); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (a_s_valid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL single_after got %0h/%0h want 0/0", a_s_valid, a_busy); end
    tick();
  endtask

  task automatic test_contention();
    int r0, r1;
    logic exp;
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h4; m0_we = 1'b1; m0_wdata = 32'h11;
    m1_valid = 1'b1; m1_addr = 32'h8; m1_we = 1'b1; m1_wdata = 32'h22;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2) != 0;
      r0 = 0; r1 = 0;
      s_ready = 1'b0;
      @(negedge clk);
      checks++; if (a_s_valid !== 1'b0 || a_m0_ready !== 1'b0 || a_m1_ready !== 1'b0) begin errors++; $display("FAIL contend_idle%0d got %0h/%0h/%0h want 0/0/0", k, a_s_valid, a_m0_ready, a_m1_ready); end
      tick();
      for (int w = 0; w < 3; w++) begin
        s_ready = (w == 2); s_rdata = $urandom;
        @(negedge clk);
        checks++; if (a_owner !== exp || a_s_valid !== 1'b1) begin errors++; $display("FAIL contend_owner%0d got %0h/%0h want %0h/1", k, a_owner, a_s_valid, exp); end
        checks++; if (a_s_addr !== (exp ? 32'h8 : 32'h4) || a_s_wdata !== (exp ? 32'h22 : 32'h11) || a_s_we !== 1'b1) begin errors++; $display("FAIL contend_req%0d got %0h/%0h/%0h", k, a_s_addr, a_s_wdata, a_s_we); end
        r0 += int'(a_m0_ready);
        r1 += int'(a_m1_ready);
        tick();
      end
      checks++; if (r0 != (exp ? 0 : 1) || r1 != (exp ? 1 : 0)) begin errors++; $display("FAIL contend_readies%0d got %0d/%0d want %0d/%0d", k, r0, r1, exp ? 0 : 1, exp ? 1 : 0); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    logic exp;
    do_reset();
    m1_valid = 1'b1; m1_addr = 32'h20; m1_we = 1'b0; s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    tick();
    for (int c = 1; c <= 4; c++) begin
      exp = (c == 4);
      @(negedge clk);
      checks++; if (a_m1_ready !== exp || a_timeout !== exp) begin errors++; $display("FAIL timeout_c%0d got ready %0h to %0h want %0h", c, a_m1_ready, a_timeout, exp); end
      checks++; if (a_m1_rdata !== '0 || a_s_valid !== 1'b1 || a_owner !== 1'b1) begin errors++; $display("FAIL timeout_bus_c%0d got %0h/%0h/%0h want 0/1/1", c, a_m1_rdata, a_s_valid, a_owner); end
      tick();
    end
    m1_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_s_valid !== 1'b0 || a_timeout !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL timeout_after got %0h/%0h/%0h want 0/0/0", a_s_valid, a_timeout, a_busy); end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h30; m0_we = 1'b0;
    @(negedge clk);
    tick();
    for (int c = 1; c <= 3; c++) begin
      s_ready = (c == 3); s_rdata = 32'h12345678;
      @(negedge clk);
      if (c < 3) begin
        checks++; if (b_m0_ready !== 1'b0 || b_timeout !== 1'b0) begin errors++; $display("FAIL simul_wait_c%0d got %0h/%0h want 0/0", c, b_m0_ready, b_timeout); end
      end else begin
        checks++; if (b_m0_ready !== 1'b1 || b_m0_rdata !== 32'h12345678 || b_timeout !== 1'b0) begin errors++; $display("FAIL simul_hit got %0h/%0h/%0h want 1/12345678/0", b_m0_ready, b_m0_rdata, b_timeout); end
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (b_s_valid !== 1'b0) begin errors++; $display("FAIL simul_after got %0h want 0", b_s_valid); end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h40; m0_we = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (a_s_valid !== 1'b1) begin errors++; $display("FAIL midrst_busy got %0h want 1", a_s_valid); end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m1_valid = 1'b1; m1_addr = 32'h44;
    @(negedge clk);
    checks++; if (a_s_valid !== 1'b0 || a_m0_ready !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL midrst_after got %0h/%0h/%0h want 0/0/0", a_s_valid, a_m0_ready, a_busy); end
    tick();
    s_ready = 1'b1; s_rdata = 32'h55AA;
    @(negedge clk);
    checks++; if (a_owner !== 1'b0 || a_s_addr !== 32'h40 || a_s_valid !== 1'b1) begin errors++; $display("FAIL midrst_regrant got %0h/%0h/%0h want 0/40/1", a_owner, a_s_addr, a_s_valid); end
    checks++; if (a_m0_ready !== 1'b1 || a_m0_rdata !== 32'h55AA || a_m1_ready !== 1'b0) begin errors++; $display("FAIL midrst_resp got %0h/%0h/%0h want 1/55aa/0", a_m0_ready, a_m0_rdata, a_m1_ready); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (a_m0_ready !== 1'b1 || a_m1_ready !== 1'b1 || a_s_valid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL idle_c%0d got %0h%0h%0h%0h want 1100", i, a_m0_ready, a_m1_ready, a_s_valid, a_busy); end
      tick();
    end
  endtask

  // Reference model: one outstanding transaction with an owner and an elapsed-wait count.
  task automatic test_random();
    bit      mBusy = 1'b0, mWho = 1'b0, mLast = 1'b1, mWe = 1'b0;
    int      mCnt = 0;
    logic [AW-1:0] mAddr = '0;
    logic [DW-1:0] mWdata = '0;
    bit      ab, e0, e1;
    logic [DW-1:0] d0, d1;
    do_reset();
    m0_valid = 1'b1; m0_addr = $urandom; m0_we = 1'($urandom); m0_wdata = $urandom;
    m1_valid = 1'($urandom); m1_addr = $urandom; m1_we = 1'($urandom); m1_wdata = $urandom;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      ab = mBusy && !s_ready && (mCnt == int'(TA) - 1);
      e0 = !m0_valid || (mBusy && !mWho && (s_ready || ab));
      e1 = !m1_valid || (mBusy && mWho && (s_ready || ab));
      d0 = (mBusy && !mWho && s_ready) ? s_rdata : '0;
      d1 = (mBusy && mWho && s_ready) ? s_rdata : '0;
      checks++; if (a_s_valid !== mBusy || a_busy !== mBusy) begin errors++; $display("FAIL rnd_busy c%0d got %0h/%0h want %0h", i, a_s_valid, a_busy, mBusy); end
      checks++; if (a_owner !== mWho) begin errors++; $display("FAIL rnd_owner c%0d got %0h want %0h", i, a_owner, mWho); end
      checks++; if (a_s_addr !== mAddr || a_s_we !== mWe || a_s_wdata !== mWdata) begin errors++; $display("FAIL rnd_req c%0d got %0h/%0h/%0h want %0h/%0h/%0h", i, a_s_addr, a_s_we, a_s_wdata, mAddr, mWe, mWdata); end
      checks++; if (a_m0_ready !== e0 || a_m1_ready !== e1) begin errors++; $display("FAIL rnd_ready c%0d got %0h/%0h want %0h/%0h", i, a_m0_ready, a_m1_ready, e0, e1); end
      checks++; if (a_m0_rdata !== d0 || a_m1_rdata !== d1) begin errors++; $display("FAIL rnd_rdata c%0d got %0h/%0h want %0h/%0h", i, a_m0_rdata, a_m1_rdata, d0, d1); end
      checks++; if (a_timeout !== ab) begin errors++; $display("FAIL rnd_timeout c%0d got %0h want %0h", i, a_timeout, ab); end
      @(posedge clk);
      if (!mBusy) begin
        if (m0_valid || m1_valid) begin
          mWho   = (m0_valid && m1_valid) ? !mLast : m1_valid;
          mBusy  = 1'b1;
          mCnt   = 0;
          mAddr  = mWho ? m1_addr : m0_addr;
          mWe    = mWho ? m1_we : m0_we;
          mWdata = mWho ? m1_wdata : m0_wdata;
        end
      end else if (s_ready || ab) begin
        mBusy = 1'b0;
        mLast = mWho;
      end else begin
        mCnt++;
      end
      #1;
      if (e0) begin m0_valid = ($urandom % 3) != 0; m0_addr = $urandom; m0_we = 1'($urandom); m0_wdata = $urandom; end
      if (e1) begin m1_valid = ($urandom % 3) != 0; m1_addr = $urandom; m1_we = 1'($urandom); m1_wdata = $urandom; end
      s_ready = mBusy && (($urandom % 3) == 0);
      s_rdata = $urandom;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_timeout();
    test_simultaneous();
    test_reset_mid_busy();
    test_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
